// File: rtl/push_debounce_pkg.sv
// push_debounce_pkg: shared state encoding and default timing constants
package push_debounce_pkg;
  typedef enum logic [1:0] {ST_UP, ST_WAIT_DN, ST_DOWN, ST_WAIT_UP} state_t;
  localparam int DEF_STABLE_CNT = 500000;
  localparam int DEF_CNT_W = 20;
endpackage

// File: rtl/push_debounce_if.sv
// push_debounce_if: button lines in, conditioned levels, strobes and flags out
interface push_debounce_if #(parameter int N_BTN = 4);
  logic [N_BTN-1:0] push_in;
  logic [N_BTN-1:0] flag_clr;
  logic [N_BTN-1:0] push_out;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] press_flag;
  modport master (output push_in, flag_clr, input push_out, press_pulse, release_pulse, press_flag);
  modport slave (input push_in, flag_clr, output push_out, press_pulse, release_pulse, press_flag);
endinterface

// File: rtl/push_debounce_chan.sv
// debounce_chan: one button channel with synchroniser, debounce FSM, counter and sticky flag
module debounce_chan import push_debounce_pkg::*; #(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int CNT_W = DEF_CNT_W,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_in,
  input  logic flag_clr,
  output logic push_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_flag
);
  localparam logic REL = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
  logic [1:0] sync;
  logic s;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt;
  logic done, counting;
  assign s = sync[1] ^ REL;
  assign cnt_inc = cnt + 1'b1;
  assign done = cnt_inc == LAST;
  assign counting = (state == ST_WAIT_DN && s) || (state == ST_WAIT_UP && !s);
  assign cnt_nxt = counting ? cnt_inc : '0;
  // two-flop synchroniser, parked at the released level during reset
  always_ff @(posedge clk)
    sync <= rst ? {2{REL}} : {sync[0], push_in};
  // next state: the counter reaches its last value on the same edge the level is accepted
  always_comb begin
    state_nxt = state;
    case (state)
      ST_UP:      state_nxt = s ? ST_WAIT_DN : ST_UP;
      ST_WAIT_DN: state_nxt = !s ? ST_UP : done ? ST_DOWN : ST_WAIT_DN;
      ST_DOWN:    state_nxt = !s ? ST_WAIT_UP : ST_DOWN;
      ST_WAIT_UP: state_nxt = s ? ST_DOWN : done ? ST_UP : ST_WAIT_UP;
      default:    state_nxt = ST_UP;
    endcase
  end
  // state, counter and registered outputs; a press strobe beats a same-cycle flag clear
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_UP;
      cnt <= '0;
      push_out <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      press_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      push_out <= state_nxt == ST_DOWN || state_nxt == ST_WAIT_UP;
      press_pulse <= state == ST_WAIT_DN && state_nxt == ST_DOWN;
      release_pulse <= state == ST_WAIT_UP && state_nxt == ST_UP;
      press_flag <= press_pulse | (press_flag & ~flag_clr);
    end
endmodule

// File: rtl/push_debounce.sv
// push_debounce: N_BTN independent debounced push-button channels
module push_debounce import push_debounce_pkg::*; #(
  parameter int N_BTN = 4,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int CNT_W = DEF_CNT_W,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst,
  push_debounce_if.slave bus
);
  logic [N_BTN-1:0] push_out, press_pulse, release_pulse, press_flag;
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT(STABLE_CNT),
      .CNT_W(CNT_W),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .push_in(bus.push_in[i]),
      .flag_clr(bus.flag_clr[i]),
      .push_out(push_out[i]),
      .press_pulse(press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .press_flag(press_flag[i])
    );
  end
  assign bus.push_out = push_out;
  assign bus.press_pulse = press_pulse;
  assign bus.release_pulse = release_pulse;
  assign bus.press_flag = press_flag;
endmodule

// File: tb/tb_push_debounce.sv
// tb_push_debounce: table vectors, corner sequences and random stimulus against a run-length model
module tb_push_debounce;
  localparam int N = 4;
  localparam int SC = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  push_debounce_if #(.N_BTN(N)) bus ();
  push_debounce #(.N_BTN(N), .STABLE_CNT(SC), .CNT_W(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  // model: a channel flips its accepted level once SC consecutive synchronised samples disagree with it
  bit d0[N], d1[N], lvl[N], mpp[N], mrp[N], mfl[N];
  int run[N];

  typedef struct {
    int n;
    bit r;
    logic [3:0] pin, clr, po, pp, rp, fl;
    string name;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got po/pp/rp/fl=%h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [N-1:0] epo, epp, erp, efl;
    bit s, nf;
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        d0[c] = 1; d1[c] = 1; lvl[c] = 0; run[c] = 0; mpp[c] = 0; mrp[c] = 0; mfl[c] = 0;
      end else begin
        s = !d1[c];
        nf = mpp[c] | (mfl[c] & !bus.flag_clr[c]);
        mfl[c] = nf;
        run[c] = (s != lvl[c]) ? run[c] + 1 : 0;
        mpp[c] = 0;
        mrp[c] = 0;
        if (run[c] == SC) begin
          lvl[c] = s;
          mpp[c] = s;
          mrp[c] = !s;
          run[c] = 0;
        end
        d1[c] = d0[c];
        d0[c] = bus.push_in[c];
      end
    end
    #1;
    for (int c = 0; c < N; c++) begin
      epo[c] = lvl[c]; epp[c] = mpp[c]; erp[c] = mrp[c]; efl[c] = mfl[c];
    end
    chk("model", {bus.push_out, bus.press_pulse, bus.release_pulse, bus.press_flag}, {epo, epp, erp, efl});
  endtask

  task automatic add(input int n, input bit r, input logic [3:0] pin, clr, po, pp, rp, fl, input string name);
    vec_t v;
    v.n = n; v.r = r; v.pin = pin; v.clr = clr; v.po = po; v.pp = pp; v.rp = rp; v.fl = fl; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    int pcount, pidx;
    logic [3:0] pin;
    rst = 1'b1;
    bus.push_in = 4'hF;
    bus.flag_clr = 4'h0;
    add(3, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "reset");
    add(5, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "idle");
    add(9, 0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "press_pre");
    add(1, 0, 4'hE, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, "press_edge");
    add(1, 0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, "press_flag");
    add(3, 0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, "held");
    add(9, 0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, "rel_pre");
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, "rel_edge");
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, "rel_after");
    add(1, 0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, "flag_clr");
    add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "flag_stays_clr");
    add(9, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "c2_pre");
    add(1, 0, 4'hB, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, "c2_pulse");
    add(1, 0, 4'hB, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4, "collide");
    add(1, 0, 4'hB, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, "c2_clr");
    add(10, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, "c2_rel");
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "c2_idle");
    add(9, 0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "m_pre");
    add(1, 0, 4'h6, 4'h0, 4'h9, 4'h9, 4'h0, 4'h0, "m_pulse");
    add(1, 0, 4'h6, 4'h0, 4'h9, 4'h0, 4'h0, 4'h9, "m_flag");
    add(10, 0, 4'hF, 4'h9, 4'h0, 4'h0, 4'h9, 4'h0, "m_rel");
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "m_idle");
    add(8, 0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "rst_pre");
    add(1, 1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "rst_mid");
    add(9, 0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "rst_wait");
    add(1, 0, 4'hE, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, "rst_repress");
    add(10, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, "rst_rel");
    add(1, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "clr_all");
    add(10, 0, 4'hE, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, "d_press");
    add(2, 0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, "d_held");
    add(1, 1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "d_rst");
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "d_after");
    add(12, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "d_quiet");
    foreach (tbl[i]) begin
      rst = tbl[i].r;
      bus.push_in = tbl[i].pin;
      bus.flag_clr = tbl[i].clr;
      repeat (tbl[i].n) tick();
      chk(tbl[i].name, {bus.push_out, bus.press_pulse, bus.release_pulse, bus.press_flag},
          {tbl[i].po, tbl[i].pp, tbl[i].rp, tbl[i].fl});
    end
    pcount = 0;
    pidx = -1;
    for (int i = 0; i < 40; i++) begin
      bus.push_in = {2'b11, (i < 20 && (i / 3) % 2 == 1), 1'b1};
      tick();
      if (bus.press_pulse[1] === 1'b1) begin
        pcount++;
        pidx = i;
      end
    end
    chk("bounce_count", 16'(pcount), 16'd1);
    chk("bounce_when", 16'(pidx), 16'd27);
    chk("bounce_level", {12'h0, bus.push_out}, 16'h0002);
    bus.push_in = 4'hF;
    repeat (12) tick();
    bus.flag_clr = 4'hF;
    tick();
    chk("bounce_cleanup", {bus.push_out, bus.press_pulse, bus.release_pulse, bus.press_flag}, 16'h0000);
    bus.flag_clr = 4'h0;
    pin = 4'hF;
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 3) == 0) pin[$urandom_range(0, 3)] ^= 1'b1;
      bus.push_in = pin;
      bus.flag_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/push_debounce.md
# push_debounce

Multi-channel push-button conditioner sitting directly upstream of the CPU's push-button PIO input, and usable as a direct PWM-control input. Each raw, asynchronous, bouncing button line is synchronised into CLK and debounced by a per-channel state machine. The block outputs a clean pressed-level, single-cycle press/release strobes, and a sticky press flag that software clears.

## Interface
- N_BTN, 4, number of button channels
- STABLE_CNT, 500000, cycles a new level must persist before acceptance (10 ms at 50 MHz); legal range 2..2^CNT_W-1
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > STABLE_CNT
- ACTIVE_LOW, 1, 1 = raw line reads 0 when pressed

- CLK  in  1  sole clock
- RST  in  1  synchronous reset, active-high
- PUSH_IN  in  N_BTN  raw button lines, asynchronous to CLK
- PUSH_OUT  out  N_BTN  debounced level, 1 = pressed, regardless of ACTIVE_LOW
- PRESS_PULSE  out  N_BTN  1-cycle strobe on accepted press
- RELEASE_PULSE  out  N_BTN  1-cycle strobe on accepted release
- PRESS_FLAG  out  N_BTN  sticky, set by a press
- FLAG_CLR  in  N_BTN  per-channel clear for PRESS_FLAG

## Operation
- Per channel, a 2-flop synchroniser samples PUSH_IN. The synchroniser output is inverted when ACTIVE_LOW=1, giving the normalised level `s` (1 = pressed).
- The FSM has four states per channel:
  - UP: stable released. If s=1, load counter to 0 and go to WAIT_DN.
  - WAIT_DN: if s=0, return to UP and clear the counter. Else if counter = STABLE_CNT-1, go to DOWN and assert PRESS_PULSE for one cycle. Else increment the counter.
  - DOWN: stable pressed. If s=0, load counter to 0 and go to WAIT_UP.
  - WAIT_UP: mirror of WAIT_DN. On s=1 return to DOWN. On counter = STABLE_CNT-1, go to UP and assert RELEASE_PULSE.
- PUSH_OUT = 1 in DOWN and WAIT_UP, 0 in UP and WAIT_DN. PUSH_OUT is registered and changes in the same cycle as the corresponding pulse.
- PRESS_FLAG:
  - Set on PRESS_PULSE, cleared when FLAG_CLR=1.
  - If set and clear occur in the same cycle, set wins.
  - FLAG_CLR has no other effect.
- Any glitch shorter than STABLE_CNT cycles after synchronisation causes no output activity. The counter restarts from 0 on every bounce.
- The counter never exceeds STABLE_CNT-1, so it cannot wrap.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.

## Timing
- Reset values:
  - Synchroniser flops: released level (1 if ACTIVE_LOW, else 0).
  - FSM: UP; counters: 0.
  - PUSH_OUT, PRESS_PULSE, RELEASE_PULSE, PRESS_FLAG: 0.
- Reset asserted mid-debounce or while DOWN returns the channel to UP immediately, with no pulse emitted.
- A button held through reset is re-accepted as a fresh press after the full latency below.
- Latency: if PUSH_IN changes and is first captured at rising edge k, then `s` is valid after edge k+1. The counter reaches STABLE_CNT-1 and PUSH_OUT plus the pulse assert after edge k+1+STABLE_CNT.
- Pulse width is exactly 1 cycle. The minimum spacing between a press pulse and a release pulse on one channel is STABLE_CNT cycles.

## Structure
- Package push_debounce_pkg holds:
  - the state enum {ST_UP, ST_WAIT_DN, ST_DOWN, ST_WAIT_UP};
  - default constants for STABLE_CNT and CNT_W.
- Sub-module debounce_chan holds one channel (synchroniser, FSM, counter, flag). push_debounce instantiates N_BTN copies in a generate loop and concatenates the outputs.

## Test plan
All scenarios use STABLE_CNT=8 and ACTIVE_LOW=1.
- Clean press: PUSH_IN[0] 1→0 at edge k and held. Required: PUSH_OUT[0]=1 and PRESS_PULSE[0]=1 after edge k+9 only; PRESS_FLAG[0]=1 from the next cycle.
- Bounce: PUSH_IN[1] toggles every 3 cycles for 20 cycles, then holds 0. Required: no pulse during the toggling; exactly one press pulse 9 edges after the final transition.
- Release and flag: from pressed, PUSH_IN[0] 0→1 held. Required: RELEASE_PULSE[0] for 1 cycle; PRESS_FLAG[0] stays 1 until FLAG_CLR[0]=1, then reads 0.
- Set/clear collision: FLAG_CLR[2]=1 on the same cycle as PRESS_PULSE[2]. Required: PRESS_FLAG[2]=1.
- Reset mid-operation: assert RST at 5 counts into WAIT_DN. Required: all outputs 0 and no pulse. With the button still held after RST deasserts, a press pulse follows STABLE_CNT+2 edges later.
- Multi-channel: channels 0 and 3 pressed on the same edge. Required: coincident PRESS_PULSE=4'b1001.
